// File: rtl/alu_reservation_station.sv
// Integer ALU reservation station: issues into the lowest free slot, snoops both CDBs, and dispatches the lowest ready slot.
// Latency is 1 cycle from operands-valid to a registered broadcast; an issue while full (available=0) is dropped.
module alu_reservation_station #(
   parameter int ENTRIES  = 4,
   parameter int ROB_W    = 3,
   parameter int TYPE_ALU = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        funcUnitEnable,
   input  logic [2:0]                  operatorType,
   input  logic [2:0]                  operatorSubType,
   input  logic                        operatorFlag,
   input  logic [ROB_W-1:0]            robNum,
   input  logic [31:0]                 data1,
   input  logic [31:0]                 data2,
   input  logic [ROB_W-1:0]            q1,
   input  logic [ROB_W-1:0]            q2,
   input  logic                        ready1,
   input  logic                        ready2,
   input  logic [31:0]                 value1,
   input  logic [31:0]                 value2,
   input  logic                        CDBiscast,
   input  logic [ROB_W-1:0]            CDBrobNum,
   input  logic [31:0]                 CDBdata,
   input  logic                        CDBiscast2,
   input  logic [ROB_W-1:0]            CDBrobNum2,
   input  logic [31:0]                 CDBdata2,
   output logic                        available,
   output logic [$clog2(ENTRIES)-1:0]  index,
   output logic                        broadcast,
   output logic [ROB_W-1:0]            robNum_out,
   output logic [31:0]                 data_out
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] busy;
   logic [2:0]         op_q   [ENTRIES];
   logic               flag_q [ENTRIES];
   logic [ROB_W-1:0]   rob_q  [ENTRIES];
   logic [31:0]        v1_q   [ENTRIES];
   logic [31:0]        v2_q   [ENTRIES];
   logic [ROB_W-1:0]   t1_q   [ENTRIES];
   logic [ROB_W-1:0]   t2_q   [ENTRIES];

   logic               disp_vld;
   logic [IDX_W-1:0]   disp_idx;
   logic [31:0]        disp_res;
   logic               issue_vld;
   logic [ROB_W+31:0]  opnd1, opnd2;

   // Returns {pending tag, value}; a zero tag means the value is already usable.
   function automatic logic [ROB_W+31:0] resolve(
      input logic [ROB_W-1:0] q, input logic rdy, input logic [31:0] d, input logic [31:0] v,
      input logic c1, input logic [ROB_W-1:0] c1_tag, input logic [31:0] c1_dat,
      input logic c2, input logic [ROB_W-1:0] c2_tag, input logic [31:0] c2_dat);
      if (q == '0)                 return {{ROB_W{1'b0}}, d};
      else if (rdy)                return {{ROB_W{1'b0}}, v};
      else if (c1 && c1_tag == q)  return {{ROB_W{1'b0}}, c1_dat};
      else if (c2 && c2_tag == q)  return {{ROB_W{1'b0}}, c2_dat};
      else                         return {q, 32'd0};
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op, input logic uns,
                                       input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return uns ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
         3'd6:    return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   // Descending scans so the lowest-numbered qualifying slot wins.
   always_comb begin
      available = 1'b0;
      index     = '0;
      disp_vld  = 1'b0;
      disp_idx  = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            available = 1'b1;
            index     = i[IDX_W-1:0];
         end
         if (busy[i] && t1_q[i] == '0 && t2_q[i] == '0) begin
            disp_vld = 1'b1;
            disp_idx = i[IDX_W-1:0];
         end
      end
   end

   assign disp_res  = alu(op_q[disp_idx], flag_q[disp_idx], v1_q[disp_idx], v2_q[disp_idx]);
   assign issue_vld = funcUnitEnable && (operatorType == TYPE_ALU[2:0]) && available;
   assign opnd1 = resolve(q1, ready1, data1, value1, CDBiscast, CDBrobNum, CDBdata,
                          CDBiscast2, CDBrobNum2, CDBdata2);
   assign opnd2 = resolve(q2, ready2, data2, value2, CDBiscast, CDBrobNum, CDBdata,
                          CDBiscast2, CDBrobNum2, CDBdata2);

   always_ff @(posedge clock) begin
      if (reset) begin
         busy       <= '0;
         broadcast  <= 1'b0;
         robNum_out <= '0;
         data_out   <= '0;
      end else begin
         broadcast <= disp_vld;
         if (disp_vld) begin
            data_out      <= disp_res;
            robNum_out    <= rob_q[disp_idx];
            busy[disp_idx] <= 1'b0;
         end
         // The issue slot is free before this edge, so snooping never touches it.
         for (int i = 0; i < ENTRIES; i++) begin
            if (busy[i]) begin
               if (t1_q[i] != '0) begin
                  if (CDBiscast && CDBrobNum == t1_q[i]) begin
                     v1_q[i] <= CDBdata;
                     t1_q[i] <= '0;
                  end else if (CDBiscast2 && CDBrobNum2 == t1_q[i]) begin
                     v1_q[i] <= CDBdata2;
                     t1_q[i] <= '0;
                  end
               end
               if (t2_q[i] != '0) begin
                  if (CDBiscast && CDBrobNum == t2_q[i]) begin
                     v2_q[i] <= CDBdata;
                     t2_q[i] <= '0;
                  end else if (CDBiscast2 && CDBrobNum2 == t2_q[i]) begin
                     v2_q[i] <= CDBdata2;
                     t2_q[i] <= '0;
                  end
               end
            end
         end
         if (issue_vld) begin
            busy[index]   <= 1'b1;
            op_q[index]   <= operatorSubType;
            flag_q[index] <= operatorFlag;
            rob_q[index]  <= robNum;
            t1_q[index]   <= opnd1[ROB_W+31:32];
            v1_q[index]   <= opnd1[31:0];
            t2_q[index]   <= opnd2[ROB_W+31:32];
            v2_q[index]   <= opnd2[31:0];
         end
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with a slot-level reference model checked every cycle.
module tb_alu_reservation_station;

   localparam int N = 4;

   logic        clock = 1'b0;
   logic        reset, funcUnitEnable, operatorFlag, ready1, ready2;
   logic [2:0]  operatorType, operatorSubType, robNum, q1, q2;
   logic [31:0] data1, data2, value1, value2, CDBdata, CDBdata2;
   logic        CDBiscast, CDBiscast2;
   logic [2:0]  CDBrobNum, CDBrobNum2;
   logic        available, broadcast;
   logic [1:0]  index;
   logic [2:0]  robNum_out;
   logic [31:0] data_out;

   alu_reservation_station dut (
      .clock(clock), .reset(reset), .funcUnitEnable(funcUnitEnable),
      .operatorType(operatorType), .operatorSubType(operatorSubType),
      .operatorFlag(operatorFlag), .robNum(robNum), .data1(data1), .data2(data2),
      .q1(q1), .q2(q2), .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
      .CDBiscast(CDBiscast), .CDBrobNum(CDBrobNum), .CDBdata(CDBdata),
      .CDBiscast2(CDBiscast2), .CDBrobNum2(CDBrobNum2), .CDBdata2(CDBdata2),
      .available(available), .index(index), .broadcast(broadcast),
      .robNum_out(robNum_out), .data_out(data_out));

   always #5 clock = ~clock;

   int tests = 0, fails = 0;

   // Reference model: one record per slot, plus the expected registered outputs.
   bit          m_busy [N];
   bit [2:0]    m_op   [N];
   bit          m_fl   [N];
   bit [2:0]    m_rob  [N];
   bit [31:0]   m_v1 [N], m_v2 [N];
   bit [2:0]    m_t1 [N], m_t2 [N];
   bit          m_ok = 0;
   logic        e_bc;
   logic [2:0]  e_rob;
   logic [31:0] e_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [31:0] ref_alu(input bit [2:0] op, input bit uns, input bit [31:0] a, input bit [31:0] b);
      bit [31:0] r;
      int sh;
      sh = b % 32;
      case (op)
         0: r = a + b;
         1: r = a + ~b + 1;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: if (uns || a[31] == b[31]) r = (a < b) ? 1 : 0;
            else r = a[31] ? 1 : 0;
         6: begin r = a; for (int k = 0; k < sh; k++) r = r * 2; end
         default: begin r = a; for (int k = 0; k < sh; k++) r = r / 2; end
      endcase
      return r;
   endfunction

   task automatic resolve(input bit [2:0] q, input bit rdy, input bit [31:0] d, input bit [31:0] v,
                          output bit [31:0] val, output bit [2:0] tag);
      tag = 0;
      if (q == 0) val = d;
      else if (rdy) val = v;
      else if (CDBiscast && CDBrobNum == q) val = CDBdata;
      else if (CDBiscast2 && CDBrobNum2 == q) val = CDBdata2;
      else begin val = 0; tag = q; end
   endtask

   task automatic snoop(inout bit [31:0] v, inout bit [2:0] t);
      if (t != 0) begin
         if (CDBiscast && CDBrobNum == t) begin v = CDBdata; t = 0; end
         else if (CDBiscast2 && CDBrobNum2 == t) begin v = CDBdata2; t = 0; end
      end
   endtask

   task automatic model_edge();
      int fs, ds;
      if (reset) begin
         for (int i = 0; i < N; i++) m_busy[i] = 0;
         e_bc = 0; e_rob = 0; e_data = 0; m_ok = 1;
         return;
      end
      fs = -1; ds = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (!m_busy[i]) fs = i;
         if (m_busy[i] && m_t1[i] == 0 && m_t2[i] == 0) ds = i;
      end
      e_bc = (ds >= 0);
      if (ds >= 0) begin
         e_data = ref_alu(m_op[ds], m_fl[ds], m_v1[ds], m_v2[ds]);
         e_rob  = m_rob[ds];
         m_busy[ds] = 0;
      end
      for (int i = 0; i < N; i++)
         if (m_busy[i]) begin snoop(m_v1[i], m_t1[i]); snoop(m_v2[i], m_t2[i]); end
      if (funcUnitEnable && operatorType == 1 && fs >= 0) begin
         m_busy[fs] = 1; m_op[fs] = operatorSubType; m_fl[fs] = operatorFlag; m_rob[fs] = robNum;
         resolve(q1, ready1, data1, value1, m_v1[fs], m_t1[fs]);
         resolve(q2, ready2, data2, value2, m_v2[fs], m_t2[fs]);
      end
   endtask

   // One clock: check the combinational free-slot outputs, advance model, check registered outputs.
   task automatic tick();
      int fs;
      if (m_ok) begin
         fs = -1;
         for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) fs = i;
         chk("available", {31'd0, available}, (fs >= 0) ? 1 : 0);
         if (fs >= 0) chk("index", {30'd0, index}, fs);
      end
      @(posedge clock);
      model_edge();
      #1;
      if (m_ok) begin
         chk("broadcast", {31'd0, broadcast}, {31'd0, e_bc});
         chk("robNum_out", {29'd0, robNum_out}, {29'd0, e_rob});
         chk("data_out", data_out, e_data);
      end
   endtask

   task automatic idle();
      reset = 0; funcUnitEnable = 0; operatorType = 0; operatorSubType = 0; operatorFlag = 0;
      robNum = 0; data1 = 0; data2 = 0; q1 = 0; q2 = 0; ready1 = 0; ready2 = 0;
      value1 = 0; value2 = 0; CDBiscast = 0; CDBrobNum = 0; CDBdata = 0;
      CDBiscast2 = 0; CDBrobNum2 = 0; CDBdata2 = 0;
   endtask

   task automatic iss(input bit [2:0] sub, input bit fl, input bit [2:0] rob,
                      input bit [31:0] d1, input bit [31:0] d2, input bit [2:0] t1, input bit [2:0] t2);
      idle();
      funcUnitEnable = 1; operatorType = 1; operatorSubType = sub; operatorFlag = fl;
      robNum = rob; data1 = d1; data2 = d2; q1 = t1; q2 = t2;
   endtask

   bit [2:0]  vs [8] = '{1, 5, 5, 6, 7, 2, 4, 0};
   bit        vf [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
   bit [31:0] va [8] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h80000000, 32'hF0F0, 32'hFF, 32'h7FFFFFFF};
   bit [31:0] vb [8] = '{1, 1, 1, 33, 31, 32'hFF00, 32'h0F, 1};
   bit [31:0] vx [8] = '{32'hFFFFFFFF, 1, 0, 2, 1, 32'hF000, 32'hF0, 32'h80000000};

   initial begin
      idle();
      reset = 1;
      tick();
      idle();
      #1;
      chk("rst_bc", {31'd0, broadcast}, 0);
      chk("rst_rob", {29'd0, robNum_out}, 0);
      chk("rst_data", data_out, 0);
      chk("rst_avail", {31'd0, available}, 1);
      chk("rst_index", {30'd0, index}, 0);

      // ADD 5+7
      iss(0, 0, 1, 5, 7, 0, 0); tick();
      idle(); tick();
      chk("add_bc", {31'd0, broadcast}, 1);
      chk("add_data", data_out, 12);
      chk("add_rob", {29'd0, robNum_out}, 1);
      tick();
      chk("add_pulse", {31'd0, broadcast}, 0);

      // OR with q1 resolved by CDB2
      iss(3, 0, 3, 0, 32'h00F, 2, 0); tick();
      idle(); CDBiscast2 = 1; CDBrobNum2 = 2; CDBdata2 = 32'h0F0; tick();
      idle(); tick();
      chk("or_data", data_out, 32'h0FF);
      chk("or_rob", {29'd0, robNum_out}, 3);
      tick();

      // Fill all slots waiting on tag 5, then a dropped fifth issue
      for (int i = 0; i < 4; i++) begin iss(0, 0, 3'(i + 1), 0, 10 * i, 5, 0); tick(); end
      chk("full_avail", {31'd0, available}, 0);
      iss(0, 0, 6, 0, 0, 0, 0); tick();
      idle(); CDBiscast = 1; CDBrobNum = 5; CDBdata = 1; tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wake_rob", {29'd0, robNum_out}, i + 1);
         chk("wake_data", data_out, 1 + 10 * i);
      end
      tick();
      chk("wake_done", {31'd0, broadcast}, 0);

      // Back-to-back ALU ops: each result appears the cycle after its issue
      for (int k = 0; k <= 8; k++) begin
         if (k < 8) iss(vs[k], vf[k], 3'(k % 7 + 1), va[k], vb[k], 0, 0); else idle();
         tick();
         if (k > 0) chk("alu_vec", data_out, vx[k - 1]);
      end
      idle(); tick();

      // ROB-ready operand, same-cycle CDB1 at issue, wrong operator type
      iss(0, 0, 2, 0, 3, 4, 0); ready1 = 1; value1 = 10; tick();
      iss(0, 0, 3, 1, 0, 0, 6); CDBiscast = 1; CDBrobNum = 6; CDBdata = 100; tick();
      chk("ready_data", data_out, 13);
      iss(0, 0, 4, 1, 1, 0, 0); operatorType = 2; tick();
      chk("cdb_issue_data", data_out, 101);
      idle(); tick();
      chk("wrong_type", {31'd0, broadcast}, 0);

      // Both CDBs match a pending tag: CDB1 wins
      iss(0, 0, 5, 0, 0, 3, 0); tick();
      idle(); CDBiscast = 1; CDBrobNum = 3; CDBdata = 32'hAA;
      CDBiscast2 = 1; CDBrobNum2 = 3; CDBdata2 = 32'hBB; tick();
      idle(); tick();
      chk("cdb_prio", data_out, 32'hAA);
      tick();

      // Pending op flushed by reset never broadcasts
      iss(0, 0, 2, 0, 0, 7, 0); tick();
      idle(); reset = 1; tick();
      idle(); CDBiscast = 1; CDBrobNum = 7; CDBdata = 9; tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_nobc", {31'd0, broadcast}, 0);
      end
      chk("flush_avail", {31'd0, available}, 1);
      chk("flush_index", {30'd0, index}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
